// File: rtl/ieeedrv_rom_arbiter_pkg.sv
// Shared types and limits for the drive-CPU ROM arbiter.
// The FSM state type, the parameter limits and the rom_select width helper
// live here so the interface, the picker and the top agree on them.

package ieeedrv_rom_arbiter_pkg;

    // Transaction phases: grant in IDLE, one issue cycle, RDLAT wait cycles, one capture cycle
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_CAPT  = 2'd3
    } arb_state_t;

    // Largest channel count and ROM read latency the arbiter is built for
    localparam int ARB_MAX_NCH   = 8;
    localparam int ARB_MAX_RDLAT = 3;

    // Width of the latency counter; sized for the worst-case latency so that
    // every legal RDLAT shares the same counter
    localparam int ARB_CNT_W = $clog2(ARB_MAX_RDLAT);

    // rom_select width; a single channel still gets a one-bit select so the
    // external data mux never sees a zero-width bus
    function automatic int sel_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/ieeedrv_rom_arbiter_if.sv
// Bus between the drive CPUs, the arbiter and the shared ROM.
// The arbiter is the master: it answers channel requests and drives the ROM
// address/select. The slave view is the channel plus ROM side.

interface ieeedrv_rom_arbiter_if #(
    parameter int NCH = 4,
    parameter int AW  = 14,
    parameter int DW  = 8
);

    localparam int SW = ieeedrv_rom_arbiter_pkg::sel_width(NCH);

    // Channel side
    logic [NCH-1:0]         req;
    logic [NCH-1:0][AW-1:0] addr;
    logic [NCH-1:0]         ack;
    logic [NCH-1:0][DW-1:0] data;

    // ROM side
    logic [SW-1:0]          rom_select;
    logic [AW-1:0]          rom_addr;
    logic [DW-1:0]          rom_q;

    // Status
    logic                   busy;

    modport master (
        input  req,
        input  addr,
        output ack,
        output data,
        output rom_select,
        output rom_addr,
        input  rom_q,
        output busy
    );

    modport slave (
        output req,
        output addr,
        input  ack,
        input  data,
        input  rom_select,
        input  rom_addr,
        output rom_q,
        input  busy
    );

endinterface

// File: rtl/ieeedrv_rom_arbiter_rr_pick.sv
// Combinational rotating-priority picker.
// The channel just after 'last' has highest priority, wrapping modulo N, so
// the most recently served channel is always considered last.

module ieeedrv_rom_arbiter_rr_pick
    import ieeedrv_rom_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] last,
    output logic [SW-1:0] grant_idx,
    output logic          any
);

    logic [SW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester after 'last' is the final winner
    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int k = N; k >= 1; k--) begin
            idx = SW'((int'(last) + k) % N);
            if (req[idx]) begin
                grant_idx = idx;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ieeedrv_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM among NCH drive CPUs.
// One transaction at a time: grant in IDLE (address and select registered),
// an issue cycle, RDLAT wait cycles for the ROM, then a capture cycle that
// writes the channel's data register and pulses its ack for one cycle.
// rom_select/rom_addr stay put from grant until the next grant, so the
// external ROM data mux is stable throughout a read. Deasserting en only
// blocks new grants; a read already granted always completes.

module ieeedrv_rom_arbiter
    import ieeedrv_rom_arbiter_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int AW    = 14,
    parameter int DW    = 8,
    parameter int RDLAT = 1
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  en,
    ieeedrv_rom_arbiter_if.master bus
);

    localparam int SW = sel_width(NCH);

    arb_state_t             state;
    arb_state_t             state_nxt;
    logic [ARB_CNT_W-1:0]   cnt;
    logic [ARB_CNT_W-1:0]   cnt_nxt;

    logic [SW-1:0]          last;
    logic [SW-1:0]          pick_idx;
    logic                   pick_any;
    logic                   grant;
    logic                   capture;

    logic [SW-1:0]          sel_q;
    logic [AW-1:0]          addr_q;
    logic                   busy_q;
    logic [NCH-1:0]         ack_q;
    logic [NCH-1:0][DW-1:0] data_q;

    ieeedrv_rom_arbiter_rr_pick #(
        .N  (NCH),
        .SW (SW)
    ) u_pick (
        .req       (bus.req),
        .last      (last),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // Next-state logic: decide grant/capture strobes and advance the latency counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        grant     = 1'b0;
        capture   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (en && pick_any) begin
                    grant     = 1'b1;
                    state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                cnt_nxt   = ARB_CNT_W'(RDLAT - 1);
                state_nxt = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ARB_CAPT;
                end else begin
                    cnt_nxt = cnt - ARB_CNT_W'(1);
                end
            end
            ARB_CAPT: begin
                capture   = 1'b1;
                state_nxt = ARB_IDLE;
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    // State and latency counter registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARB_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Grant bookkeeping: owner, ROM address and round-robin pointer are latched at grant; busy spans grant to capture
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sel_q  <= '0;
            addr_q <= '0;
            last   <= SW'(NCH - 1);
            busy_q <= 1'b0;
        end else if (grant) begin
            sel_q  <= pick_idx;
            addr_q <= bus.addr[pick_idx];
            last   <= pick_idx;
            busy_q <= 1'b1;
        end else if (capture) begin
            busy_q <= 1'b0;
        end
    end

    // Capture: store ROM data for the owning channel and pulse its ack for one cycle
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ack_q  <= '0;
            data_q <= '0;
        end else begin
            ack_q <= '0;
            if (capture) begin
                ack_q[sel_q]  <= 1'b1;
                data_q[sel_q] <= bus.rom_q;
            end
        end
    end

    assign bus.ack        = ack_q;
    assign bus.data       = data_q;
    assign bus.rom_select = sel_q;
    assign bus.rom_addr   = addr_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_ieeedrv_rom_arbiter.sv
// Testbench for ieeedrv_rom_arbiter.
// Two arbiters (RDLAT=1 and RDLAT=3) see the same channel stimulus. Each has
// its own ROM model and a transaction-level reference model that only knows
// "a grant goes to the next requester after the last one, and its data shows
// up RDLAT+2 edges later"; every output is compared against it each cycle.
// Directed sequences add fixed-number checks for latency, grant order,
// en gating, mid-read reset and request/address changes after grant.

`timescale 1ns/1ps

module tb_ieeedrv_rom_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 14;
    localparam int DW  = 8;

    logic                   clk_sys = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   en      = 1'b0;
    logic [NCH-1:0]         req_drv = '0;
    logic [NCH-1:0][AW-1:0] addr_drv = '0;

    int  err_count   = 0;
    int  check_count = 0;
    bit  run_checks  = 1'b0;

    always #5 clk_sys = ~clk_sys;

    // ROM contents: a scrambled function of the address
    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        logic [15:0] p;
        p = 16'(a) * 16'd40503;
        return p[13:6] ^ a[7:0];
    endfunction

    task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_cfg
        localparam int RL = (k == 0) ? 1 : 3;

        ieeedrv_rom_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();

        logic [DW-1:0] rom_pipe [RL];

        assign bus.req   = req_drv;
        assign bus.addr  = addr_drv;
        assign bus.rom_q = rom_pipe[RL-1];

        ieeedrv_rom_arbiter #(
            .NCH   (NCH),
            .AW    (AW),
            .DW    (DW),
            .RDLAT (RL)
        ) dut (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .en      (en),
            .bus     (bus)
        );

        // Synchronous ROM: rom_q reflects rom_addr RL clocks later
        always @(posedge clk_sys) begin
            rom_pipe[0] <= rom_fn(bus.rom_addr);
            for (int s = 1; s < RL; s++) rom_pipe[s] <= rom_pipe[s-1];
        end

        // Reference model state
        logic [NCH-1:0]         m_ack   = '0;
        logic [NCH-1:0][DW-1:0] m_data  = '0;
        logic [AW-1:0]          m_raddr = '0;
        int                     m_sel   = 0;
        int                     m_last  = NCH - 1;
        int                     m_left  = 0;
        bit                     m_busy  = 1'b0;

        // Transaction-level model: grant, then results RL+2 edges later, next grant one edge after that
        initial begin
            forever begin
                @(posedge clk_sys or negedge reset_n);
                if (!reset_n) begin
                    m_ack   = '0;
                    m_data  = '0;
                    m_raddr = '0;
                    m_sel   = 0;
                    m_last  = NCH - 1;
                    m_left  = 0;
                    m_busy  = 1'b0;
                end else begin
                    m_ack = '0;
                    if (m_busy) begin
                        m_left--;
                        if (m_left == 0) begin
                            m_data[m_sel] = rom_fn(m_raddr);
                            m_ack[m_sel]  = 1'b1;
                            m_busy        = 1'b0;
                        end
                    end else if (en && req_drv != '0) begin
                        int pick;
                        pick = -1;
                        for (int i = 1; i <= NCH; i++) begin
                            if (pick < 0 && req_drv[(m_last + i) % NCH]) pick = (m_last + i) % NCH;
                        end
                        m_sel   = pick;
                        m_last  = pick;
                        m_raddr = addr_drv[pick];
                        m_busy  = 1'b1;
                        m_left  = RL + 2;
                    end
                end
            end
        end

        // Compare every output against the model away from the active edge
        always @(negedge clk_sys) begin
            if (run_checks) begin
                check_output($sformatf("cfg%0d ack", k),  64'(bus.ack),        64'(m_ack));
                check_output($sformatf("cfg%0d busy", k), 64'(bus.busy),       64'(m_busy));
                check_output($sformatf("cfg%0d sel", k),  64'(bus.rom_select), 64'(m_sel));
                check_output($sformatf("cfg%0d addr", k), 64'(bus.rom_addr),   64'(m_raddr));
                check_output($sformatf("cfg%0d data", k), 64'(bus.data),       64'(m_data));
            end
        end
    end

    // Count negedges until ack[ch] is seen on each arbiter; -1 if the budget runs out
    task automatic wait_acks(input int ch, input int budget, output int lat0, output int lat1);
        lat0 = -1;
        lat1 = -1;
        for (int n = 1; n <= budget && (lat0 < 0 || lat1 < 0); n++) begin
            @(negedge clk_sys);
            if (lat0 < 0 && g_cfg[0].bus.ack[ch]) lat0 = n;
            if (lat1 < 0 && g_cfg[1].bus.ack[ch]) lat1 = n;
        end
    endtask

    // Reset values must appear on both arbiters without waiting for a clock
    task automatic check_reset_values(input string tag);
        check_output({tag, " busy0"}, 64'(g_cfg[0].bus.busy),       64'd0);
        check_output({tag, " ack0"},  64'(g_cfg[0].bus.ack),        64'd0);
        check_output({tag, " data0"}, 64'(g_cfg[0].bus.data),       64'd0);
        check_output({tag, " sel0"},  64'(g_cfg[0].bus.rom_select), 64'd0);
        check_output({tag, " addr0"}, 64'(g_cfg[0].bus.rom_addr),   64'd0);
        check_output({tag, " busy1"}, 64'(g_cfg[1].bus.busy),       64'd0);
        check_output({tag, " data1"}, 64'(g_cfg[1].bus.data),       64'd0);
        check_output({tag, " addr1"}, 64'(g_cfg[1].bus.rom_addr),   64'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk_sys);
        #2 reset_n = 1'b0;
        #1 check_reset_values("reset");
        @(negedge clk_sys);
        #2 reset_n = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic apply_stimulus();
        int l0, l1;
        int order[$];
        int stamp[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};

        // Single read on channel 2: ack RDLAT+3 negedges after the request goes up
        @(negedge clk_sys);
        en          = 1'b1;
        addr_drv[2] = 14'h1234;
        req_drv     = 4'b0100;
        wait_acks(2, 20, l0, l1);
        check_output("t1 lat rd1", 64'(l0), 64'd4);
        check_output("t1 lat rd3", 64'(l1), 64'd6);
        check_output("t1 data rd1", 64'(g_cfg[0].bus.data[2]), 64'(rom_fn(14'h1234)));
        check_output("t1 data rd3", 64'(g_cfg[1].bus.data[2]), 64'(rom_fn(14'h1234)));
        check_output("t1 sel rd3",  64'(g_cfg[1].bus.rom_select), 64'd2);
        req_drv = '0;
        idle_cycles(8);

        // All channels requesting from a fresh pointer: grants rotate 0,1,2,3,0 back to back
        apply_reset();
        addr_drv = {14'h3F0F, 14'h2222, 14'h0AB1, 14'h0100};
        req_drv  = 4'b1111;
        for (int n = 0; n < 40 && order.size() < 5; n++) begin
            @(negedge clk_sys);
            for (int c = 0; c < NCH; c++) begin
                if (g_cfg[0].bus.ack[c]) begin
                    order.push_back(c);
                    stamp.push_back(n);
                end
            end
        end
        check_output("t2 ack count", 64'(order.size()), 64'd5);
        for (int i = 0; i < order.size() && i < 5; i++) begin
            check_output($sformatf("t2 grant %0d", i), 64'(order[i]), 64'(exp_order[i]));
            if (i > 0) check_output($sformatf("t2 gap %0d", i), 64'(stamp[i] - stamp[i-1]), 64'd4);
        end
        req_drv = '0;
        idle_cycles(10);

        // en low blocks the grant; raising it grants at the next edge; dropping it mid-read still completes
        en      = 1'b0;
        req_drv = 4'b0010;
        addr_drv[1] = 14'h0555;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk_sys);
            check_output("t4 hold busy0", 64'(g_cfg[0].bus.busy), 64'd0);
            check_output("t4 hold busy1", 64'(g_cfg[1].bus.busy), 64'd0);
        end
        en = 1'b1;
        @(negedge clk_sys);
        check_output("t4 grant busy0", 64'(g_cfg[0].bus.busy), 64'd1);
        check_output("t4 grant sel1",  64'(g_cfg[1].bus.rom_select), 64'd1);
        en = 1'b0;
        wait_acks(1, 20, l0, l1);
        check_output("t4 ack rd1", 64'(l0), 64'd3);
        check_output("t4 ack rd3", 64'(l1), 64'd5);
        req_drv = '0;
        idle_cycles(4);
        en = 1'b1;

        // Reset while both arbiters are waiting on the ROM, then channel 0 is served normally
        addr_drv[2] = 14'h0777;
        req_drv     = 4'b0100;
        idle_cycles(2);
        #2 reset_n = 1'b0;
        req_drv    = '0;
        #1 check_reset_values("t5 async");
        @(negedge clk_sys);
        #2 reset_n = 1'b1;
        idle_cycles(8);
        addr_drv[0] = 14'h0042;
        req_drv     = 4'b0001;
        wait_acks(0, 20, l0, l1);
        check_output("t5 lat rd1", 64'(l0), 64'd4);
        check_output("t5 lat rd3", 64'(l1), 64'd6);
        check_output("t5 data rd3", 64'(g_cfg[1].bus.data[0]), 64'(rom_fn(14'h0042)));
        req_drv = '0;
        idle_cycles(8);

        // Request dropped and address changed one cycle after grant: old address is read
        addr_drv[3] = 14'h2ABC;
        req_drv     = 4'b1000;
        @(negedge clk_sys);
        req_drv     = '0;
        addr_drv[3] = 14'h1555;
        wait_acks(3, 20, l0, l1);
        check_output("t6 lat rd1", 64'(l0), 64'd3);
        check_output("t6 lat rd3", 64'(l1), 64'd5);
        check_output("t6 data rd1", 64'(g_cfg[0].bus.data[3]), 64'(rom_fn(14'h2ABC)));
        check_output("t6 data rd3", 64'(g_cfg[1].bus.data[3]), 64'(rom_fn(14'h2ABC)));
        idle_cycles(8);

        // Random traffic: requests toggle, addresses wander while idle, en mostly high
        for (int n = 0; n < 400; n++) begin
            @(negedge clk_sys);
            en = ($urandom_range(0, 9) != 0);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 3) == 0) req_drv[c] = ~req_drv[c];
                if (!req_drv[c] || $urandom_range(0, 7) == 0) addr_drv[c] = AW'($urandom);
            end
        end
        req_drv = '0;
        en      = 1'b1;
        idle_cycles(12);
    endtask

    initial begin
        $display("[TB] ieeedrv_rom_arbiter bench start");
        @(negedge clk_sys);
        run_checks = 1'b1;
        check_reset_values("por");
        #2 reset_n = 1'b1;
        idle_cycles(2);
        apply_stimulus();
        run_checks = 1'b0;
        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
